// File: rtl/echo_pkg.sv
// Shared types and helpers for the echo delay line: default widths, volume
// limits, controller state encoding and a generic signed saturator.
package echo_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int ADDR_W_DEF   = 16;

    localparam logic [31:0] VOL_MIN = 32'd1;
    localparam logic [31:0] VOL_MAX = 32'd6;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        READ,
        MIX
    } state_t;

    // Clamp a signed value into the range of a w-bit two's complement word.
    function automatic logic signed [31:0] sat(input logic signed [31:0] s, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/echo_delay_line_if.sv
// Sample stream and control bundle between the echo controller / codec side
// (master) and the echo datapath (slave).
interface echo_delay_line_if
    import echo_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
);
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       sample_valid;
    logic [31:0]                delay_time;
    logic [31:0]                delay_volume;
    logic                       disabled;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       out_valid;
    logic                       ready;
    logic                       overrun;

    modport master (
        output sample_in, sample_valid, delay_time, delay_volume, disabled,
        input  sample_out, out_valid, ready, overrun
    );

    modport slave (
        input  sample_in, sample_valid, delay_time, delay_volume, disabled,
        output sample_out, out_valid, ready, overrun
    );
endinterface

// File: rtl/echo_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered output (one cycle of read latency), suitable for block RAM.
module echo_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/echo_delay_line.sv
// Feedback echo: each accepted sample is mixed with an attenuated copy of the
// buffer contents delay_time samples back, and the mix is recorded in the buffer.
module echo_delay_line
    import echo_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    echo_delay_line_if.slave  bus
);
    localparam logic [31:0] MAX_DELAY = 32'((64'd1 << ADDR_W) - 64'd1);

    state_t                     state_reg, state_next;
    logic [ADDR_W-1:0]          clr_addr_reg;
    logic [ADDR_W-1:0]          wr_ptr_reg;
    logic [ADDR_W-1:0]          rd_addr_reg;
    logic [2:0]                 v_reg;
    logic signed [SAMPLE_W-1:0] x_reg;
    logic                       bypass_reg;
    logic signed [SAMPLE_W-1:0] sample_out_reg;
    logic                       out_valid_reg;
    logic                       overrun_reg;

    logic [ADDR_W-1:0]          d_clamped;
    logic [2:0]                 v_clamped;
    logic                       accept;
    logic                       ram_we;
    logic [ADDR_W-1:0]          ram_wr_addr;
    logic [SAMPLE_W-1:0]        ram_wr_data;
    logic signed [SAMPLE_W-1:0] ram_q;
    logic signed [SAMPLE_W-1:0] echo;
    logic signed [SAMPLE_W:0]   sum;
    logic signed [SAMPLE_W-1:0] y;

    echo_ram #(
        .DATA_W (SAMPLE_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLK     (CLK),
        .we      (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_addr (rd_addr_reg),
        .rd_data (ram_q)
    );

    always_comb begin
        d_clamped = ADDR_W'(bus.delay_time);
        if (bus.delay_time == 32'd0) begin
            d_clamped = ADDR_W'(1);
        end else if (bus.delay_time > MAX_DELAY) begin
            d_clamped = '1;
        end

        v_clamped = bus.delay_volume[2:0];
        if (bus.delay_volume < VOL_MIN) begin
            v_clamped = 3'(VOL_MIN);
        end else if (bus.delay_volume > VOL_MAX) begin
            v_clamped = 3'(VOL_MAX);
        end
    end

    // One guard bit is enough: |echo| <= |x|-range/2, so x + echo never wraps.
    always_comb begin
        echo = ram_q >>> v_reg;
        sum  = {x_reg[SAMPLE_W-1], x_reg} + {echo[SAMPLE_W-1], echo};
        if (bypass_reg) begin
            y = x_reg;
        end else begin
            y = SAMPLE_W'(sat(32'(sum), SAMPLE_W));
        end
    end

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        ram_we      = 1'b0;
        ram_wr_addr = wr_ptr_reg;
        ram_wr_data = y;
        unique case (state_reg)
            CLEAR: begin
                ram_we      = 1'b1;
                ram_wr_addr = clr_addr_reg;
                ram_wr_data = '0;
                if (clr_addr_reg == {ADDR_W{1'b1}}) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (bus.sample_valid) begin
                    accept     = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                state_next = MIX;
            end
            MIX: begin
                ram_we     = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= CLEAR;
            clr_addr_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_addr_reg    <= '0;
            v_reg          <= 3'(VOL_MIN);
            x_reg          <= '0;
            bypass_reg     <= 1'b0;
            sample_out_reg <= '0;
            out_valid_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= (state_reg == MIX);
            overrun_reg   <= bus.sample_valid && (state_reg != IDLE);
            if (state_reg == CLEAR) begin
                clr_addr_reg <= clr_addr_reg + 1'b1;
            end
            if (accept) begin
                x_reg       <= bus.sample_in;
                v_reg       <= v_clamped;
                bypass_reg  <= bus.disabled;
                rd_addr_reg <= wr_ptr_reg - d_clamped;
            end
            if (state_reg == MIX) begin
                wr_ptr_reg     <= wr_ptr_reg + 1'b1;
                sample_out_reg <= y;
            end
        end
    end

    assign bus.sample_out = sample_out_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.ready      = (state_reg == IDLE);
    assign bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_echo_delay_line.sv
// Directed bench for echo_delay_line with a 256-sample buffer; expected values
// are worked out by hand from the buffer history noted beside each step.
module tb_echo_delay_line;
    localparam int SW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic CLK;
    logic RST;
    int   total;
    int   bad;

    echo_delay_line_if #(.SAMPLE_W(SW)) bus ();

    echo_delay_line #(
        .SAMPLE_W (SW),
        .ADDR_W   (AW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count cycles from reset release until ready, watching for stray out_valid.
    task automatic wait_clear(input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        do begin
            @(posedge CLK); #1;
            n++;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end while (bus.ready !== 1'b1 && n < 1000);
        chk({tag, "_len"}, n, DEPTH);
        chk({tag, "_ov"}, 32'(seen), 0);
    endtask

    // Present one sample, then check out_valid timing and the output value.
    task automatic send(input string tag, input int s, input logic [31:0] dt,
                        input logic [31:0] dv, input bit dis, input int exp);
        int   n;
        logic ov1;
        n = 0;
        while (bus.ready !== 1'b1 && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, "_rdy"}, 32'(bus.ready), 1);
        @(negedge CLK);
        bus.sample_in    = 16'(s);
        bus.delay_time   = dt;
        bus.delay_volume = dv;
        bus.disabled     = dis;
        bus.sample_valid = 1'b1;
        @(posedge CLK); #1;
        bus.sample_valid = 1'b0;
        @(posedge CLK); #1;
        ov1 = bus.out_valid;
        @(posedge CLK); #1;
        chk({tag, "_lat"}, {30'd0, ov1, bus.out_valid}, 1);
        chk(tag, bus.sample_out, exp);
    endtask

    initial begin
        int imp_exp [0:12];
        total = 0;
        bad   = 0;
        RST              = 1'b1;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.delay_time   = 32'd4;
        bus.delay_volume = 32'd1;
        bus.disabled     = 1'b0;

        // Reset state and clear sweep length.
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_ovalid", 32'(bus.out_valid), 0);
        chk("rst_out", bus.sample_out, 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        @(negedge CLK);
        RST = 1'b0;
        wait_clear("clear");

        // Impulse, delay 4, volume 1 (buffer addresses 0..12).
        imp_exp = '{16384, 0, 0, 0, 8192, 0, 0, 0, 4096, 0, 0, 0, 2048};
        for (int i = 0; i < 13; i++) begin
            send("impulse", (i == 0) ? 16384 : 0, 4, 1, 1'b0, imp_exp[i]);
        end

        // Saturation with delay 1; a bypassed zero flushes the previous sample.
        send("sat_flush", 0, 1, 1, 1'b1, 0);
        send("sat_p0", 30000, 1, 1, 1'b0, 30000);
        send("sat_p1", 30000, 1, 1, 1'b0, 32767);
        send("sat_p2", 30000, 1, 1, 1'b0, 32767);
        send("sat_flush2", 0, 1, 1, 1'b1, 0);
        send("sat_n0", -30000, 1, 1, 1'b0, -30000);
        send("sat_n1", -30000, 1, 1, 1'b0, -32768);
        send("sat_n2", -30000, 1, 1, 1'b0, -32768);

        // Clamping of delay and volume (addresses 21..25).
        send("clamp_flush", 0, 1, 1, 1'b1, 0);
        send("clamp_seed", 1000, 0, 1, 1'b0, 1000);
        send("clamp_dt0", 0, 0, 1, 1'b0, 500);
        send("clamp_dv0", 0, 1, 0, 1'b0, 250);
        send("clamp_dv9", 0, 1, 9, 1'b0, 3);

        // Seed address 26, wrap the pointer, then read it back from DEPTH-1 behind.
        send("wrap_seed", 5000, 1, 1, 1'b1, 5000);
        for (int i = 0; i < 254; i++) begin
            send("fill", 0, 1, 1, 1'b1, 0);
        end
        send("clamp_dtmax", 0, 70000, 1, 1'b0, 2500);

        // Bypass: dry samples still recorded, echo appears once re-enabled.
        send("byp_flush0", 0, 1, 1, 1'b1, 0);
        send("byp_flush1", 0, 1, 1, 1'b1, 0);
        send("byp_n0", 16384, 4, 1, 1'b1, 16384);
        send("byp_n1", 0, 4, 1, 1'b1, 0);
        send("byp_n2", 0, 4, 1, 1'b0, 0);
        send("byp_n3", 0, 4, 1, 1'b0, 0);
        send("byp_n4", 0, 4, 1, 1'b0, 8192);
        send("byp_n5", 0, 4, 1, 1'b0, 0);

        // Strobe while in READ is dropped and flagged once.
        @(negedge CLK);
        bus.sample_in    = 16'sd100;
        bus.delay_time   = 32'd1;
        bus.delay_volume = 32'd1;
        bus.disabled     = 1'b1;
        bus.sample_valid = 1'b1;
        @(posedge CLK); #1;
        bus.sample_valid = 1'b0;
        @(negedge CLK);
        bus.sample_in    = 16'sd7777;
        bus.sample_valid = 1'b1;
        @(posedge CLK); #1;
        bus.sample_valid = 1'b0;
        chk("ovr_pulse", 32'(bus.overrun), 1);
        chk("ovr_busy", 32'(bus.ready), 0);
        @(posedge CLK); #1;
        chk("ovr_once", 32'(bus.overrun), 0);
        chk("ovr_ovalid", 32'(bus.out_valid), 1);
        chk("ovr_out", bus.sample_out, 100);
        send("ovr_next", 0, 1, 1, 1'b0, 50);

        // Strobe on the MIX->IDLE edge is dropped as well.
        @(negedge CLK);
        bus.sample_in    = 16'sd300;
        bus.disabled     = 1'b1;
        bus.sample_valid = 1'b1;
        @(posedge CLK); #1;
        bus.sample_valid = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        bus.sample_in    = 16'sd999;
        bus.sample_valid = 1'b1;
        @(posedge CLK); #1;
        bus.sample_valid = 1'b0;
        chk("mix_ovr", 32'(bus.overrun), 1);
        chk("mix_out", bus.sample_out, 300);
        @(posedge CLK); #1;
        chk("mix_idle", 32'(bus.ready), 1);

        // Reset while a sample is in READ: no output, full sweep again.
        @(negedge CLK);
        bus.sample_in    = 16'sd1234;
        bus.sample_valid = 1'b1;
        @(posedge CLK); #1;
        bus.sample_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("rr_ovalid", 32'(bus.out_valid), 0);
        chk("rr_ready", 32'(bus.ready), 0);
        @(negedge CLK);
        RST = 1'b0;
        wait_clear("reclear");
        chk("rr_out", bus.sample_out, 0);
        // Address 36 held 300 and address 28 held 16384 before the reset.
        send("rr_stale36", 0, 220, 1, 1'b0, 0);
        send("rr_stale28", 0, 229, 1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
